// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap/return sequencer.
// Cause codes follow the RV32 privileged encoding; the MSB marks an interrupt.
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAVE   = 3'd1,
    ST_VECTOR = 3'd2,
    ST_RET    = 3'd3,
    ST_DRAIN  = 3'd4
  } state_e;

  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
  localparam logic [31:0] CAUSE_MEI        = 32'h8000_000B;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

endpackage

// File: rtl/trap_target.sv
// Trap vector computation: direct mode (and all exceptions) jump to the mtvec base,
// vectored-mode interrupts jump to base + 4*cause. Reserved modes act as direct.
module trap_target
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_cause,
  output logic [XLEN-1:0] o_target
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;
  logic            is_irq;

  always_comb begin
    base   = i_mtvec & ~XLEN'(3);
    // The interrupt flag and bit XLEN-2 shift out, leaving cause[XLEN-2:0]<<2 truncated.
    offset = i_cause << 2;
    is_irq = i_cause[XLEN-1];
    if ((i_mtvec[1:0] == MTVEC_VECTORED) && is_irq) begin
      o_target = base + offset;
    end else begin
      o_target = base;
    end
  end

endmodule

// File: rtl/trap_seq.sv
// Machine-mode trap and xRET sequencer: saves mepc/mcause, updates mstatus,
// redirects fetch and holds the pipeline for a fixed drain window.
module trap_seq
  import trap_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_excp_en,
  input  logic [XLEN-1:0] i_excp,
  input  logic            i_return,
  input  logic            i_irq,
  input  logic            i_mie,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  output logic            o_kill,
  output logic            o_stall,
  output logic            o_flush,
  output logic            o_mepc_we,
  output logic [XLEN-1:0] o_mepc,
  output logic            o_mcause_we,
  output logic [XLEN-1:0] o_mcause,
  output logic            o_mstatus_trap,
  output logic            o_mstatus_ret,
  output logic            o_redirect_en,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_busy
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;

  logic            flush_q, flush_d;
  logic            mepc_we_q, mepc_we_d;
  logic            mcause_we_q, mcause_we_d;
  logic            mstatus_trap_q, mstatus_trap_d;
  logic            mstatus_ret_q, mstatus_ret_d;
  logic            redirect_en_q, redirect_en_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            busy_q, busy_d;

  logic            take_irq, take_exc, take_ret, take;
  logic [XLEN-1:0] vec_target;

  trap_target #(.XLEN(XLEN)) u_target (
    .i_mtvec  (i_mtvec),
    .i_cause  (cause_q),
    .o_target (vec_target)
  );

  always_comb begin
    take_irq = i_valid & i_irq & i_mie;
    take_exc = i_valid & i_excp_en;
    take_ret = i_valid & i_return;
    // Requests are only honoured from IDLE; reset masks the decision so kill stays low.
    take     = i_rst_n & (state_q == ST_IDLE) & (take_irq | take_exc | take_ret);

    state_d = state_q;
    cnt_d   = cnt_q;
    epc_d   = epc_q;
    cause_d = cause_q;

    case (state_q)
      ST_IDLE: begin
        if (take_irq) begin
          epc_d   = i_pc;
          cause_d = {1'b1, (XLEN-1)'(CAUSE_MEI[30:0])};
          state_d = ST_SAVE;
        end else if (take_exc) begin
          epc_d   = i_pc;
          cause_d = i_excp;
          state_d = ST_SAVE;
        end else if (take_ret) begin
          state_d = ST_RET;
        end
      end
      ST_SAVE:   state_d = ST_VECTOR;
      ST_VECTOR: begin
        state_d = ST_DRAIN;
        cnt_d   = DRAIN_LOAD;
      end
      ST_RET: begin
        state_d = ST_DRAIN;
        cnt_d   = DRAIN_LOAD;
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are decoded from the state being entered.
    mepc_we_d      = (state_d == ST_SAVE);
    mcause_we_d    = (state_d == ST_SAVE);
    mstatus_trap_d = (state_d == ST_SAVE);
    mstatus_ret_d  = (state_d == ST_RET);
    flush_d        = (state_d == ST_SAVE) | (state_d == ST_VECTOR) | (state_d == ST_RET);
    redirect_en_d  = (state_d == ST_VECTOR) | (state_d == ST_RET);
    busy_d         = (state_d != ST_IDLE);
    if (state_d == ST_VECTOR)   redirect_pc_d = vec_target;
    else if (state_d == ST_RET) redirect_pc_d = i_mepc & ~XLEN'(3);
    else                        redirect_pc_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      epc_q          <= '0;
      cause_q        <= '0;
      flush_q        <= 1'b0;
      mepc_we_q      <= 1'b0;
      mcause_we_q    <= 1'b0;
      mstatus_trap_q <= 1'b0;
      mstatus_ret_q  <= 1'b0;
      redirect_en_q  <= 1'b0;
      redirect_pc_q  <= '0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      epc_q          <= epc_d;
      cause_q        <= cause_d;
      flush_q        <= flush_d;
      mepc_we_q      <= mepc_we_d;
      mcause_we_q    <= mcause_we_d;
      mstatus_trap_q <= mstatus_trap_d;
      mstatus_ret_q  <= mstatus_ret_d;
      redirect_en_q  <= redirect_en_d;
      redirect_pc_q  <= redirect_pc_d;
      busy_q         <= busy_d;
    end
  end

  assign o_kill         = take;
  assign o_stall        = busy_q | take;
  assign o_flush        = flush_q;
  assign o_mepc_we      = mepc_we_q;
  assign o_mepc         = epc_q;
  assign o_mcause_we    = mcause_we_q;
  assign o_mcause       = cause_q;
  assign o_mstatus_trap = mstatus_trap_q;
  assign o_mstatus_ret  = mstatus_ret_q;
  assign o_redirect_en  = redirect_en_q;
  assign o_redirect_pc  = redirect_pc_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_trap_seq.sv
// Directed testbench for trap_seq: ecall, ebreak, interrupt, mret, priority and reset-in-SAVE.
module tb_trap_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_pc = '0;
  logic        i_excp_en = 1'b0;
  logic [31:0] i_excp = '0;
  logic        i_return = 1'b0;
  logic        i_irq = 1'b0;
  logic        i_mie = 1'b0;
  logic [31:0] i_mtvec = '0;
  logic [31:0] i_mepc = '0;
  logic        o_kill, o_stall, o_flush, o_mepc_we, o_mcause_we;
  logic        o_mstatus_trap, o_mstatus_ret, o_redirect_en, o_busy;
  logic [31:0] o_mepc, o_mcause, o_redirect_pc;

  int checks = 0;
  int errors = 0;

  trap_seq #(.XLEN(32), .DRAIN_CYCLES(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_pc(i_pc),
    .i_excp_en(i_excp_en), .i_excp(i_excp), .i_return(i_return), .i_irq(i_irq),
    .i_mie(i_mie), .i_mtvec(i_mtvec), .i_mepc(i_mepc),
    .o_kill(o_kill), .o_stall(o_stall), .o_flush(o_flush),
    .o_mepc_we(o_mepc_we), .o_mepc(o_mepc), .o_mcause_we(o_mcause_we), .o_mcause(o_mcause),
    .o_mstatus_trap(o_mstatus_trap), .o_mstatus_ret(o_mstatus_ret),
    .o_redirect_en(o_redirect_en), .o_redirect_pc(o_redirect_pc), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_valid = 0; i_excp_en = 0; i_return = 0; i_irq = 0; i_mie = 0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++; if ({o_kill, o_stall, o_flush, o_mepc_we, o_mcause_we, o_mstatus_trap, o_mstatus_ret, o_redirect_en, o_busy} !== 9'b0) begin errors++; $display("FAIL reset_ctrl got %b exp 0", {o_kill, o_stall, o_flush, o_mepc_we, o_mcause_we, o_mstatus_trap, o_mstatus_ret, o_redirect_en, o_busy}); end
    checks++; if ({o_mepc, o_mcause, o_redirect_pc} !== 96'b0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", o_mepc, o_mcause, o_redirect_pc); end
    i_rst_n = 1'b1;
    tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %b exp 0", o_busy); end
    $display("reset: done");
  endtask

  task automatic test_ecall();
    i_valid = 1; i_pc = 32'h100; i_excp_en = 1; i_excp = 32'd11; i_mtvec = 32'h200;
    #1;
    checks++; if ({o_kill, o_stall} !== 2'b11) begin errors++; $display("FAIL ecall_T kill/stall got %b exp 11", {o_kill, o_stall}); end
    tick(); clear_inputs();
    checks++; if ({o_mepc_we, o_mcause_we, o_mstatus_trap, o_flush, o_redirect_en} !== 5'b11110) begin errors++; $display("FAIL ecall_T1 strobes got %b exp 11110", {o_mepc_we, o_mcause_we, o_mstatus_trap, o_flush, o_redirect_en}); end
    checks++; if (o_mepc !== 32'h100) begin errors++; $display("FAIL ecall_mepc got %h exp 100", o_mepc); end
    checks++; if (o_mcause !== 32'd11) begin errors++; $display("FAIL ecall_mcause got %h exp b", o_mcause); end
    tick();
    checks++; if ({o_redirect_en, o_flush, o_mepc_we, o_mstatus_trap} !== 4'b1100) begin errors++; $display("FAIL ecall_T2 strobes got %b exp 1100", {o_redirect_en, o_flush, o_mepc_we, o_mstatus_trap}); end
    checks++; if (o_redirect_pc !== 32'h200) begin errors++; $display("FAIL ecall_redirect got %h exp 200", o_redirect_pc); end
    tick();
    // Requests arriving while busy must be ignored.
    i_valid = 1; i_excp_en = 1; #1;
    checks++; if ({o_busy, o_stall, o_kill, o_redirect_en, o_flush} !== 5'b11000) begin errors++; $display("FAIL ecall_T3 drain got %b exp 11000", {o_busy, o_stall, o_kill, o_redirect_en, o_flush}); end
    tick();
    checks++; if ({o_busy, o_kill} !== 2'b10) begin errors++; $display("FAIL ecall_T4 drain got %b exp 10", {o_busy, o_kill}); end
    clear_inputs();
    tick();
    checks++; if ({o_busy, o_stall} !== 2'b00) begin errors++; $display("FAIL ecall_T5 idle got %b exp 00", {o_busy, o_stall}); end
    $display("ecall: pc=100 cause=b done");
  endtask

  task automatic test_ebreak();
    i_valid = 1; i_pc = 32'h180; i_excp_en = 1; i_excp = 32'd3; i_mtvec = 32'h201;
    #1;
    checks++; if (o_kill !== 1'b1) begin errors++; $display("FAIL ebreak_kill got %b exp 1", o_kill); end
    tick(); clear_inputs();
    checks++; if ({o_mcause_we, o_mcause} !== {1'b1, 32'd3}) begin errors++; $display("FAIL ebreak_mcause got %b %h exp 1 3", o_mcause_we, o_mcause); end
    tick();
    checks++; if ({o_redirect_en, o_redirect_pc} !== {1'b1, 32'h200}) begin errors++; $display("FAIL ebreak_redirect got %b %h exp 1 200", o_redirect_en, o_redirect_pc); end
    tick(); tick(); tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL ebreak_idle busy got %b exp 0", o_busy); end
    $display("ebreak: cause=3 vectored mtvec done");
  endtask

  task automatic test_irq();
    i_valid = 1; i_pc = 32'h40; i_irq = 1; i_mie = 1; i_mtvec = 32'h201;
    #1;
    checks++; if ({o_kill, o_stall} !== 2'b11) begin errors++; $display("FAIL irq_T kill/stall got %b exp 11", {o_kill, o_stall}); end
    tick(); clear_inputs();
    checks++; if (o_mcause !== 32'h8000000B) begin errors++; $display("FAIL irq_mcause got %h exp 8000000b", o_mcause); end
    checks++; if ({o_mepc_we, o_mepc} !== {1'b1, 32'h40}) begin errors++; $display("FAIL irq_mepc got %b %h exp 1 40", o_mepc_we, o_mepc); end
    tick();
    checks++; if ({o_redirect_en, o_redirect_pc} !== {1'b1, 32'h22C}) begin errors++; $display("FAIL irq_redirect got %b %h exp 1 22c", o_redirect_en, o_redirect_pc); end
    tick();
    checks++; if (o_redirect_en !== 1'b0) begin errors++; $display("FAIL irq_redirect_width got %b exp 0", o_redirect_en); end
    tick(); tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL irq_idle busy got %b exp 0", o_busy); end
    $display("irq: pc=40 vectored target 22c done");
  endtask

  task automatic test_mret();
    int busy_cycles;
    i_valid = 1; i_return = 1; i_mepc = 32'h106;
    #1;
    checks++; if ({o_kill, o_stall} !== 2'b11) begin errors++; $display("FAIL mret_T kill/stall got %b exp 11", {o_kill, o_stall}); end
    tick(); clear_inputs();
    checks++; if ({o_redirect_en, o_mstatus_ret, o_flush, o_mepc_we, o_mstatus_trap} !== 5'b11100) begin errors++; $display("FAIL mret_T1 strobes got %b exp 11100", {o_redirect_en, o_mstatus_ret, o_flush, o_mepc_we, o_mstatus_trap}); end
    checks++; if (o_redirect_pc !== 32'h104) begin errors++; $display("FAIL mret_redirect got %h exp 104", o_redirect_pc); end
    busy_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_busy === 1'b1) busy_cycles++;
      tick();
    end
    checks++; if (busy_cycles !== 3) begin errors++; $display("FAIL mret_busy_cycles got %0d exp 3", busy_cycles); end
    $display("mret: mepc=106 redirect 104 done");
  endtask

  task automatic test_priority();
    i_valid = 1; i_pc = 32'h80; i_excp_en = 1; i_excp = 32'd11; i_return = 1;
    i_irq = 1; i_mie = 1; i_mtvec = 32'h200;
    #1;
    checks++; if (o_kill !== 1'b1) begin errors++; $display("FAIL prio_kill got %b exp 1", o_kill); end
    tick(); i_excp_en = 0; i_return = 0;
    checks++; if ({o_mcause, o_mepc} !== {32'h8000000B, 32'h80}) begin errors++; $display("FAIL prio_cause got %h %h exp 8000000b 80", o_mcause, o_mepc); end
    checks++; if (o_kill !== 1'b0) begin errors++; $display("FAIL prio_busy_kill T1 got %b exp 0", o_kill); end
    tick();
    checks++; if ({o_redirect_en, o_redirect_pc, o_mstatus_ret} !== {1'b1, 32'h200, 1'b0}) begin errors++; $display("FAIL prio_redirect got %b %h %b exp 1 200 0", o_redirect_en, o_redirect_pc, o_mstatus_ret); end
    tick();
    checks++; if (o_kill !== 1'b0) begin errors++; $display("FAIL prio_busy_kill T3 got %b exp 0", o_kill); end
    tick();
    checks++; if ({o_busy, o_kill} !== 2'b10) begin errors++; $display("FAIL prio_busy_kill T4 got %b exp 10", {o_busy, o_kill}); end
    tick();
    checks++; if ({o_busy, o_kill, o_stall} !== 3'b011) begin errors++; $display("FAIL prio_retake T5 got %b exp 011", {o_busy, o_kill, o_stall}); end
    i_pc = 32'h84;
    tick(); clear_inputs();
    checks++; if ({o_mepc_we, o_mepc, o_mcause} !== {1'b1, 32'h84, 32'h8000000B}) begin errors++; $display("FAIL prio_retake_save got %b %h %h exp 1 84 8000000b", o_mepc_we, o_mepc, o_mcause); end
    tick(); tick(); tick(); tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL prio_idle busy got %b exp 0", o_busy); end
    $display("priority: irq over excp/ret, held irq retaken in first idle cycle done");
  endtask

  task automatic test_reset_in_save();
    int we_seen;
    i_valid = 1; i_pc = 32'h300; i_excp_en = 1; i_excp = 32'd11; i_mtvec = 32'h200;
    tick(); clear_inputs();
    checks++; if (o_mepc_we !== 1'b1) begin errors++; $display("FAIL rsave_in_save mepc_we got %b exp 1", o_mepc_we); end
    i_rst_n = 0; #1;
    checks++; if ({o_mepc_we, o_mcause_we, o_mstatus_trap, o_flush, o_busy, o_stall, o_redirect_en} !== 7'b0) begin errors++; $display("FAIL rsave_async got %b exp 0", {o_mepc_we, o_mcause_we, o_mstatus_trap, o_flush, o_busy, o_stall, o_redirect_en}); end
    checks++; if ({o_mepc, o_mcause, o_redirect_pc} !== 96'b0) begin errors++; $display("FAIL rsave_data got %h %h %h exp 0", o_mepc, o_mcause, o_redirect_pc); end
    tick();
    i_rst_n = 1;
    we_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (o_mepc_we === 1'b1 || o_redirect_en === 1'b1 || o_busy === 1'b1) we_seen++;
    end
    checks++; if (we_seen !== 0) begin errors++; $display("FAIL rsave_no_resume got %0d active cycles exp 0", we_seen); end
    i_valid = 1; i_excp_en = 1; i_pc = 32'h310; #1;
    checks++; if (o_kill !== 1'b1) begin errors++; $display("FAIL rsave_idle_take got %b exp 1", o_kill); end
    tick(); clear_inputs();
    checks++; if ({o_mepc_we, o_mepc} !== {1'b1, 32'h310}) begin errors++; $display("FAIL rsave_post_take got %b %h exp 1 310", o_mepc_we, o_mepc); end
    tick(); tick(); tick(); tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rsave_final_idle got %b exp 0", o_busy); end
    $display("reset_in_save: done");
  endtask

  initial begin
    test_reset();
    test_ecall();
    test_ebreak();
    test_irq();
    test_mret();
    test_priority();
    test_reset_in_save();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
